// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  // RV32I load/store func3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [3:0] lane_en_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_e;

  // Request payload latched at acceptance
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [2:0]      func3;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-port request/response bundle.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_func3;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_func3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_func3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extension for loads.
// DMEM_MISALIGN_CHECK_EN: flag misaligned accesses and suppress them;
// otherwise low address bits are masked to the natural alignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output lane_en_t        be,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned
);

  logic [1:0]      a;
  logic [4:0]      sh;
  logic [XLEN-1:0] rs;
  logic            is_half;
  logic            is_word;

  // Alignment, lane enables and load extension
  always_comb begin
    is_half    = (func3 == F3_LH) || (func3 == F3_LHU);
    is_word    = (func3 == F3_LW);
    a          = addr_lo;
    misaligned = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = (is_half && a[0]) || (is_word && (a != 2'b00));
`else
    if (is_half) a[0] = 1'b0;
    if (is_word) a    = 2'b00;
`endif
    sh       = {a, 3'b000};
    wdata_sh = wdata << sh;
    rs       = rword >> sh;

    be = 4'b0000;
    case (func3)
      F3_SB:   be = lane_en_t'(4'b0001 << a);
      F3_SH:   be = lane_en_t'(4'b0011 << a);
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    rdata_ext = rword;
    case (func3)
      F3_LB:   rdata_ext = {{24{rs[7]}}, rs[7:0]};
      F3_LH:   rdata_ext = {{16{rs[15]}}, rs[15:0]};
      F3_LW:   rdata_ext = rword;
      F3_LBU:  rdata_ext = {24'h000000, rs[7:0]};
      F3_LHU:  rdata_ext = {16'h0000, rs[15:0]};
      default: rdata_ext = rword;
    endcase

    if (misaligned) begin
      be        = 4'b0000;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES latency,
// lane-enabled stores and extended loads on an internal word RAM.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (see dmem_lane_align).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [XLEN-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0] widx;
  logic [XLEN-1:0]       raw_word;
  lane_en_t              be;
  logic [XLEN-1:0]       wdata_sh;
  logic [XLEN-1:0]       rdata_ext;
  logic                  misaligned;
  logic                  unused_addr_bits;

  // Upper address bits alias onto the array
  assign widx             = req_q.addr[ADDR_WIDTH+1:2];
  assign raw_word         = mem[widx];
  assign unused_addr_bits = ^req_q.addr[XLEN-1:ADDR_WIDTH+2];

  dmem_lane_align u_align (
    .func3      (req_q.func3),
    .addr_lo    (req_q.addr[1:0]),
    .wdata      (req_q.wdata),
    .rword      (raw_word),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  // State, request latch and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          req_d.we    = bus.req_we;
          req_d.addr  = bus.req_addr;
          req_d.func3 = bus.req_func3;
          req_d.wdata = bus.req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = req_q.we ? '0 : rdata_ext;
        rsp_err_d   = misaligned;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Lane-enabled RAM write at the ACCESS edge; contents are not reset
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && req_q.we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance b1 uses WAIT_STATES=1,
// instance b0 uses WAIT_STATES=0 for the back-to-back throughput case.
module tb_data_mem_responder;
  import dmem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  data_mem_responder_if b1 ();
  data_mem_responder_if b0 ();

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  rsp_t exp1_q[$];
  rsp_t exp0_q[$];
  int   acc1_q[$];
  int   acc0_q[$];
  int   cyc = 0;
  int   last_acc0 = -1;
  bit   burst0 = 1'b0;
  rsp_t e1, e0;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input bit v, input bit we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    if (sel == 0) begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = addr; b0.req_func3 = f3; b0.req_wdata = wd;
    end else begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = addr; b1.req_func3 = f3; b1.req_wdata = wd;
    end
  endtask

  // Issue n requests (valid held across them); optionally expect responses
  task automatic issue(input int sel, input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] er, input bit ee,
                       input int n, input bit want);
    rsp_t e;
    int   got;
    bit   rdy;
    e.rdata = er;
    e.err   = ee;
    @(posedge clk); #1;
    if (want) begin
      for (int i = 0; i < n; i++) begin
        if (sel == 0) exp0_q.push_back(e);
        else          exp1_q.push_back(e);
      end
    end
    drive(sel, 1'b1, we, addr, f3, wd);
    got = 0;
    for (int t = 0; t < 200 && got < n; t++) begin
      rdy = (sel == 0) ? b0.req_ready : b1.req_ready;
      @(posedge clk); #1;
      if (rdy) got++;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    if (got < n) check_val("accept_timeout", 32'(got), 32'(n));
    if (want) begin
      for (int t = 0; t < 200; t++) begin
        if ((sel == 0 ? exp0_q.size() : exp1_q.size()) == 0) break;
        @(negedge clk);
      end
      if (sel == 0) begin
        if (exp0_q.size() != 0) check_val("rsp_timeout0", 32'(exp0_q.size()), 32'd0);
        exp0_q.delete();
      end else begin
        if (exp1_q.size() != 0) check_val("rsp_timeout1", 32'(exp1_q.size()), 32'd0);
        exp1_q.delete();
      end
    end
  endtask

  // Response monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      acc1_q.delete();
      acc0_q.delete();
    end else begin
      if (acc1_q.size() > 0) check_val("ready_busy1", 32'(b1.req_ready), 32'd0);
      if (b1.rsp_valid) begin
        if (exp1_q.size() == 0 || acc1_q.size() == 0) begin
          check_val("spurious_rsp1", 32'd1, 32'd0);
        end else begin
          e1 = exp1_q.pop_front();
          check_val("rdata1", b1.rsp_rdata, e1.rdata);
          check_val("err1", 32'(b1.rsp_err), 32'(e1.err));
          check_val("latency1", 32'(cyc - acc1_q.pop_front()), 32'd3);
        end
      end
      if (b1.req_valid && b1.req_ready) acc1_q.push_back(cyc);

      if (acc0_q.size() > 0) check_val("ready_busy0", 32'(b0.req_ready), 32'd0);
      if (b0.rsp_valid) begin
        if (exp0_q.size() == 0 || acc0_q.size() == 0) begin
          check_val("spurious_rsp0", 32'd1, 32'd0);
        end else begin
          e0 = exp0_q.pop_front();
          check_val("rdata0", b0.rsp_rdata, e0.rdata);
          check_val("err0", 32'(b0.rsp_err), 32'(e0.err));
          check_val("latency0", 32'(cyc - acc0_q.pop_front()), 32'd2);
        end
      end
      if (b0.req_valid && b0.req_ready) begin
        if (burst0 && last_acc0 >= 0) check_val("accept_gap0", 32'(cyc - last_acc0), 32'd3);
        last_acc0 = cyc;
        acc0_q.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ready1", 32'(b1.req_ready), 32'd1);
    check_val("rst_valid1", 32'(b1.rsp_valid), 32'd0);
    check_val("rst_rdata1", b1.rsp_rdata, 32'h0);
    check_val("rst_err1",   32'(b1.rsp_err), 32'd0);
    check_val("rst_ready0", 32'(b0.req_ready), 32'd1);
    check_val("rst_rdata0", b0.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Word store/load round trip
    issue(1, 1'b1, 32'h10, F3_SW, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h10, F3_LW, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b1);

    // Byte store into a known word, then byte loads
    issue(1, 1'b1, 32'h10, F3_SW, 32'h11223344, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b1, 32'h13, F3_SB, 32'h000000AA, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h10, F3_LW,  32'h0, 32'hAA223344, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h13, F3_LB,  32'h0, 32'hFFFFFFAA, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h13, F3_LBU, 32'h0, 32'h000000AA, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h11, F3_LB,  32'h0, 32'h00000033, 1'b0, 1, 1'b1);
    // Aliasing via upper address bits and unknown-func3 load/store
    issue(1, 1'b0, 32'h0000_0410, F3_LW, 32'h0, 32'hAA223344, 1'b0, 1, 1'b1);
    issue(1, 1'b1, 32'h10, 3'b011, 32'h55555555, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h10, 3'b011, 32'h0, 32'hAA223344, 1'b0, 1, 1'b1);

    // Half store and loads
    issue(1, 1'b1, 32'h20, F3_SW, 32'h00000000, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b1, 32'h22, F3_SH, 32'h00008001, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h22, F3_LH,  32'h0, 32'hFFFF8001, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h22, F3_LHU, 32'h0, 32'h00008001, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h20, F3_LW,  32'h0, 32'h80010000, 1'b0, 1, 1'b1);

    // Misaligned word store
    issue(1, 1'b1, 32'h30, F3_SW, 32'h0BADCAFE, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b1, 32'h31, F3_SW, 32'h55667788, 32'h0, MIS_EN, 1, 1'b1);
    issue(1, 1'b0, 32'h30, F3_LW, 32'h0, MIS_EN ? 32'h0BADCAFE : 32'h55667788, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h33, F3_LHU, 32'h0, MIS_EN ? 32'h0 : (MIS_EN ? 32'h0 : 32'h00005566),
          MIS_EN, 1, 1'b1);

    // Reset in the middle of a store's WAIT phase
    issue(1, 1'b1, 32'h40, F3_SW, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h40, F3_LW, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1'b1);
    issue(1, 1'b1, 32'h40, F3_SW, 32'h12345678, 32'h0, 1'b0, 1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", 32'(b1.req_ready), 32'd1);
    check_val("midrst_rdata", b1.rsp_rdata, 32'h0);
    check_val("midrst_valid", 32'(b1.rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    issue(1, 1'b0, 32'h40, F3_LW, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1'b1);

    // Zero-wait instance: back-to-back loads with valid held
    issue(0, 1'b1, 32'h50, F3_SW, 32'hA5A50F0F, 32'h0, 1'b0, 1, 1'b1);
    burst0 = 1'b1;
    last_acc0 = -1;
    issue(0, 1'b0, 32'h50, F3_LW, 32'h0, 32'hA5A50F0F, 1'b0, 4, 1'b1);
    burst0 = 1'b0;
    issue(0, 1'b0, 32'h52, F3_LH, 32'h0, 32'hFFFFA5A5, 1'b0, 1, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
